// File: rtl/psr_controller.sv
// Processor status register controller: ALU/software flag updates plus an interrupt shadow stack.
// Optional macro PSR_STACK_TRAP_EN: trap stack overflow/underflow (sticky stack_err) instead of wrapping.
module psr_controller #(
   parameter int FLAG_W = 6,
   parameter int DEPTH  = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   alu_valid,
   input  logic [FLAG_W-1:0]      alu_flags,
   input  logic [FLAG_W-1:0]      alu_mask,
   input  logic                   sw_wr,
   input  logic [FLAG_W-1:0]      sw_data,
   input  logic                   int_save,
   input  logic                   int_restore,
   output logic [FLAG_W-1:0]      psr_out,
   output logic                   busy,
   output logic                   int_ack,
   output logic [$clog2(DEPTH):0] stack_level,
   output logic                   stack_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int I_BIT = 5;
   localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(DEPTH);
   localparam logic [FLAG_W-1:0] I_MASK  = FLAG_W'(1) << I_BIT;

   typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

   state_t            state;
   state_t            next_state;
   logic [FLAG_W-1:0] stack [DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [LVL_W-1:0]  level;
   logic              full;
   logic              empty;
   logic              push_ok;
   logic              pop_ok;

   // The write pointer wraps modulo DEPTH; level is the saturating occupancy count.
   assign full        = (level == LVL_MAX);
   assign empty       = (level == '0);
   assign busy        = (state != IDLE);
   assign stack_level = level;

`ifdef PSR_STACK_TRAP_EN
   assign push_ok = !full;
   assign pop_ok  = !empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stack_err <= 1'b0;
      end else if ((state == SAVE && full) || (state == RESTORE && empty)) begin
         stack_err <= 1'b1;
      end
   end
`else
   assign push_ok   = 1'b1;
   assign pop_ok    = 1'b1;
   assign stack_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (int_restore) begin
               next_state = RESTORE;
            end else if (int_save) begin
               next_state = SAVE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: the shadow stack is a plain memory with no reset; only ptr/level define its valid contents.
   always_ff @(posedge clock) begin
      if (state == SAVE && push_ok) begin
         stack[ptr] <= psr_out;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         psr_out <= '0;
         ptr     <= '0;
         level   <= '0;
         int_ack <= 1'b0;
      end else begin
         int_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (int_restore || int_save) begin
                  psr_out <= psr_out;
               end else if (sw_wr) begin
                  psr_out <= sw_data;
               end else if (alu_valid) begin
                  psr_out <= (psr_out & ~alu_mask) | (alu_flags & alu_mask);
               end
            end
            SAVE: begin
               int_ack <= 1'b1;
               psr_out <= psr_out & ~I_MASK;
               if (push_ok) begin
                  ptr <= ptr + PTR_W'(1);
               end
               if (!full) begin
                  level <= level + LVL_W'(1);
               end
            end
            RESTORE: begin
               int_ack <= 1'b1;
               if (pop_ok) begin
                  psr_out <= stack[ptr - PTR_W'(1)];
                  ptr     <= ptr - PTR_W'(1);
               end
               if (!empty) begin
                  level <= level - LVL_W'(1);
               end
            end
            default: begin
               psr_out <= psr_out;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psr_controller.sv
// Self-checking bench for psr_controller: directed scenarios plus randomized traffic against a queue model.
module tb_psr_controller;

   localparam int FLAG_W = 6;
   localparam int DEPTH  = 4;
   localparam int LVL_W  = 3;
`ifdef PSR_STACK_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              alu_valid = 1'b0;
   logic [FLAG_W-1:0] alu_flags = '0;
   logic [FLAG_W-1:0] alu_mask = '0;
   logic              sw_wr = 1'b0;
   logic [FLAG_W-1:0] sw_data = '0;
   logic              int_save = 1'b0;
   logic              int_restore = 1'b0;
   logic [FLAG_W-1:0] psr_out;
   logic              busy;
   logic              int_ack;
   logic [LVL_W-1:0]  stack_level;
   logic              stack_err;

   int checks = 0;
   int failures = 0;

   // Reference model: PSR value, LIFO of saved PSRs (oldest at front), sticky error.
   logic [FLAG_W-1:0] m_psr;
   logic [FLAG_W-1:0] m_q[$];
   logic              m_err;

   psr_controller #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .alu_valid(alu_valid), .alu_flags(alu_flags),
      .alu_mask(alu_mask), .sw_wr(sw_wr), .sw_data(sw_data), .int_save(int_save),
      .int_restore(int_restore), .psr_out(psr_out), .busy(busy), .int_ack(int_ack),
      .stack_level(stack_level), .stack_err(stack_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      alu_valid = 1'b0; alu_flags = '0; alu_mask = '0;
      sw_wr = 1'b0; sw_data = '0; int_save = 1'b0; int_restore = 1'b0;
   endtask

   function automatic void model_reset();
      m_psr = '0;
      m_q.delete();
      m_err = 1'b0;
   endfunction

   function automatic void model_push();
      if (m_q.size() == DEPTH) begin
         if (TRAP) m_err = 1'b1;
         else begin
            void'(m_q.pop_front());
            m_q.push_back(m_psr);
         end
      end else begin
         m_q.push_back(m_psr);
      end
      m_psr[5] = 1'b0;
   endfunction

   function automatic void model_pop();
      if (m_q.size() > 0) m_psr = m_q.pop_back();
      else if (TRAP) m_err = 1'b1;
   endfunction

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic sw_load(input logic [FLAG_W-1:0] v);
      sw_wr = 1'b1; sw_data = v;
      tick();
      clear_inputs();
      m_psr = v;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (psr_out !== 6'h00) begin failures++; $display("FAIL reset_psr got %h expected 00", psr_out); end
      checks++;
      if (busy !== 1'b0 || int_ack !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl busy=%b int_ack=%b expected 0 0", busy, int_ack);
      end
      checks++;
      if (stack_level !== 3'd0 || stack_err !== 1'b0) begin
         failures++; $display("FAIL reset_stack level=%0d err=%b expected 0 0", stack_level, stack_err);
      end
   endtask

   task automatic test_alu_update();
      logic [FLAG_W-1:0] exp;
      do_reset();
      sw_load(6'h20);
      alu_valid = 1'b1; alu_flags = 6'h03; alu_mask = 6'h0F;
      tick();
      clear_inputs();
      checks++;
      if (psr_out !== 6'h23) begin failures++; $display("FAIL alu_merge got %h expected 23", psr_out); end
      tick();
      checks++;
      if (psr_out !== 6'h23) begin failures++; $display("FAIL alu_hold got %h expected 23", psr_out); end
      // I bit only moves when its mask bit is set
      alu_valid = 1'b1; alu_flags = 6'h00; alu_mask = 6'h1F;
      tick();
      clear_inputs();
      checks++;
      if (psr_out !== 6'h20) begin failures++; $display("FAIL alu_keep_i got %h expected 20", psr_out); end
      alu_valid = 1'b1; alu_flags = 6'h00; alu_mask = 6'h20;
      tick();
      clear_inputs();
      exp = 6'h00;
      checks++;
      if (psr_out !== exp) begin failures++; $display("FAIL alu_clear_i got %h expected %h", psr_out, exp); end
      m_psr = exp;
   endtask

   task automatic test_sw_priority();
      do_reset();
      sw_wr = 1'b1; sw_data = 6'h15;
      alu_valid = 1'b1; alu_flags = 6'h3F; alu_mask = 6'h3F;
      tick();
      clear_inputs();
      checks++;
      if (psr_out !== 6'h15) begin failures++; $display("FAIL sw_over_alu got %h expected 15", psr_out); end
      // restore beats save: with empty stack and nothing else, only busy/ack timing is visible
      sw_load(6'h25);
      int_save = 1'b1; int_restore = 1'b1; sw_wr = 1'b1; sw_data = 6'h11;
      tick();
      clear_inputs();
      tick();
      checks++;
      if (TRAP && stack_err !== 1'b1) begin
         failures++; $display("FAIL restore_priority_err got %b expected 1", stack_err);
      end else if (stack_level !== 3'd0 || psr_out === 6'h11 || psr_out === 6'h05) begin
         failures++; $display("FAIL restore_priority level=%0d psr=%h expected level 0, no save/sw effect", stack_level, psr_out);
      end
   endtask

   task automatic test_save_restore();
      do_reset();
      sw_load(6'h25);
      int_save = 1'b1;
      tick();
      clear_inputs();
      checks++;
      if (busy !== 1'b1 || int_ack !== 1'b0) begin
         failures++; $display("FAIL save_busy busy=%b int_ack=%b expected 1 0", busy, int_ack);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || int_ack !== 1'b1) begin
         failures++; $display("FAIL save_ack busy=%b int_ack=%b expected 0 1", busy, int_ack);
      end
      checks++;
      if (psr_out !== 6'h05 || stack_level !== 3'd1) begin
         failures++; $display("FAIL save_state psr=%h level=%0d expected 05 1", psr_out, stack_level);
      end
      tick();
      checks++;
      if (int_ack !== 1'b0) begin failures++; $display("FAIL ack_pulse got %b expected 0", int_ack); end
      int_restore = 1'b1;
      tick();
      clear_inputs();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL restore_busy got %b expected 1", busy); end
      tick();
      checks++;
      if (int_ack !== 1'b1 || psr_out !== 6'h25 || stack_level !== 3'd0) begin
         failures++;
         $display("FAIL restore_state ack=%b psr=%h level=%0d expected 1 25 0", int_ack, psr_out, stack_level);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         sw_load(6'h20 + 6'(k));
         int_save = 1'b1;
         tick();
         clear_inputs();
         tick();
         model_push();
      end
      checks++;
      if (stack_level !== 3'd4) begin failures++; $display("FAIL ovf_level got %0d expected 4", stack_level); end
      checks++;
      if (stack_err !== m_err) begin failures++; $display("FAIL ovf_err got %b expected %b", stack_err, m_err); end
      checks++;
      if (psr_out !== m_psr) begin failures++; $display("FAIL ovf_psr got %h expected %h", psr_out, m_psr); end
      for (int k = 0; k < 4; k++) begin
         int_restore = 1'b1;
         tick();
         clear_inputs();
         tick();
         model_pop();
         checks++;
         if (psr_out !== m_psr || stack_level !== LVL_W'(m_q.size())) begin
            failures++;
            $display("FAIL ovf_pop%0d psr=%h level=%0d expected %h %0d", k, psr_out, stack_level, m_psr, m_q.size());
         end
      end
   endtask

   task automatic test_reset_during_save();
      do_reset();
      sw_load(6'h2A);
      int_save = 1'b1;
      tick();
      clear_inputs();
      tick();
      sw_load(6'h3C);
      int_save = 1'b1;
      tick();
      clear_inputs();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (psr_out !== 6'h00 || busy !== 1'b0 || stack_level !== 3'd0 || int_ack !== 1'b0) begin
         failures++;
         $display("FAIL async_reset psr=%h busy=%b level=%0d ack=%b expected 00 0 0 0", psr_out, busy, stack_level, int_ack);
      end
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      sw_load(6'h11);
      checks++;
      if (psr_out !== 6'h11) begin failures++; $display("FAIL post_reset_sample got %h expected 11", psr_out); end
   endtask

   task automatic test_busy_ignores();
      do_reset();
      sw_load(6'h27);
      int_save = 1'b1;
      tick();
      clear_inputs();
      alu_valid = 1'b1; alu_flags = 6'h3F; alu_mask = 6'h3F;
      sw_wr = 1'b1; sw_data = 6'h18;
      tick();
      clear_inputs();
      model_push();
      checks++;
      if (psr_out !== m_psr) begin failures++; $display("FAIL busy_ignore got %h expected %h", psr_out, m_psr); end
      tick();
      checks++;
      if (psr_out !== m_psr) begin failures++; $display("FAIL busy_dropped got %h expected %h", psr_out, m_psr); end
   endtask

   task automatic test_random();
      logic av, sw, is, ir;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         av = 1'($urandom_range(0, 1));
         sw = ($urandom_range(0, 3) == 0);
         is = ($urandom_range(0, 4) == 0);
         ir = ($urandom_range(0, 4) == 0) && (TRAP || m_q.size() > 0);
         alu_valid = av; alu_flags = 6'($urandom); alu_mask = 6'($urandom);
         sw_wr = sw; sw_data = 6'($urandom);
         int_save = is; int_restore = ir;
         if (ir || is) begin
            tick();
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL rnd_busy n=%0d got %b expected 1", n, busy); end
            if (ir) model_pop();
            else model_push();
            alu_valid = 1'b1; alu_flags = 6'($urandom); alu_mask = 6'($urandom);
            sw_wr = 1'($urandom); sw_data = 6'($urandom);
            int_save = 1'($urandom); int_restore = 1'($urandom);
            tick();
            checks++;
            if (int_ack !== 1'b1 || busy !== 1'b0) begin
               failures++; $display("FAIL rnd_ack n=%0d ack=%b busy=%b expected 1 0", n, int_ack, busy);
            end
         end else begin
            if (sw) m_psr = sw_data;
            else if (av) m_psr = (m_psr & ~alu_mask) | (alu_flags & alu_mask);
            tick();
            checks++;
            if (int_ack !== 1'b0 || busy !== 1'b0) begin
               failures++; $display("FAIL rnd_idle n=%0d ack=%b busy=%b expected 0 0", n, int_ack, busy);
            end
         end
         checks++;
         if (psr_out !== m_psr || stack_level !== LVL_W'(m_q.size()) || stack_err !== m_err) begin
            failures++;
            $display("FAIL rnd_state n=%0d psr=%h level=%0d err=%b expected %h %0d %b",
                     n, psr_out, stack_level, stack_err, m_psr, m_q.size(), m_err);
         end
      end
      clear_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_alu_update();
      test_sw_priority();
      test_save_restore();
      test_overflow();
      test_reset_during_save();
      test_busy_ignores();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
